// File: rtl/multicycle_seq_pkg.sv
// Shared opcodes, state encoding, instruction field slices
// and the decode bundle for the multicycle sequencer.
package multicycle_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JUMP = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int R1_HI  = 11;
  localparam int R1_LO  = 8;
  localparam int R2_HI  = 7;
  localparam int R2_LO  = 4;
  localparam int R3_HI  = 3;
  localparam int R3_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] num_reads;
    logic       is_alu;
    logic       uses_mem;
    logic       mem_write;
    logic       writes_reg;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/multicycle_seq_if.sv
// Shared memory port between the sequencer (master)
// and the instruction/data memory (slave).
interface multicycle_seq_if #(
  parameter int WORD_W = 16
);
  logic              M_REQ;
  logic              M_W;
  logic [WORD_W-1:0] MADDR;
  logic [WORD_W-1:0] MDATAOUT;
  logic [WORD_W-1:0] MDATAIN;
  logic              M_ACK;

  modport master (
    output M_REQ, M_W, MADDR, MDATAOUT,
    input  MDATAIN, M_ACK
  );

  modport slave (
    input  M_REQ, M_W, MADDR, MDATAOUT,
    output MDATAIN, M_ACK
  );
endinterface

// File: rtl/multicycle_seq_decode.sv
// Opcode classifier: how many register reads an
// instruction needs and which later states it visits.
module multicycle_seq_decode
  import multicycle_seq_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op <= OP_SLT): begin
        dec.num_reads  = 2'd2;
        dec.is_alu     = 1'b1;
        dec.writes_reg = 1'b1;
      end
      (op == OP_ADDI): begin
        dec.num_reads  = 2'd1;
        dec.writes_reg = 1'b1;
      end
      (op == OP_LW): begin
        dec.uses_mem   = 1'b1;
        dec.writes_reg = 1'b1;
      end
      (op == OP_SW): begin
        dec.num_reads  = 2'd1;
        dec.uses_mem   = 1'b1;
        dec.mem_write  = 1'b1;
      end
      (op == OP_BEQ): begin
        dec.num_reads  = 2'd2;
        dec.is_branch  = 1'b1;
      end
      (op == OP_JUMP): dec.is_jump = 1'b1;
      (op == OP_HALT): dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: fetch, operand reads,
// ALU drive, memory access, write-back and PC update.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int PC_W   = 8,
  parameter int REG_A  = 4
) (
  input  logic              DCLK,
  input  logic              RSTN,
  input  logic              RUN,
  output logic              BUSY,
  output logic              HALTED,
  output logic [PC_W-1:0]   PC_OUT,
  multicycle_seq_if.master  mem,
  output logic              R_W,
  output logic [REG_A-1:0]  RADDR,
  output logic [WORD_W-1:0] RDATAOUT,
  input  logic [WORD_W-1:0] RDATAIN,
  output logic [3:0]        SEL_OUT,
  output logic [WORD_W-1:0] DATA1_OUT,
  output logic [WORD_W-1:0] DATA2_OUT,
  input  logic [WORD_W-1:0] ALU_RES,
  input  logic              ALU_ZERO
);

  state_t            state, nxt;
  logic [WORD_W-1:0] ir, a, b, res;
  logic [PC_W-1:0]   pc, pc_val, pc_inc, pc_br;
  logic              pc_ld, done;
  logic [3:0]        op, r1, r2, r3;
  logic [7:0]        imm8;
  logic [WORD_W-1:0] imm_ext, pc_ext;
  dec_t              dec;

  assign op      = ir[OP_HI:OP_LO];
  assign r1      = ir[R1_HI:R1_LO];
  assign r2      = ir[R2_HI:R2_LO];
  assign r3      = ir[R3_HI:R3_LO];
  assign imm8    = ir[IMM_HI:IMM_LO];
  assign imm_ext = WORD_W'(imm8);
  assign pc_ext  = WORD_W'(pc);
  assign pc_inc  = pc + PC_W'(1);
  assign pc_br   = pc_inc + PC_W'($signed(r3));

  assign BUSY   = (state != S_IDLE) && (state != S_HALT);
  assign HALTED = (state == S_HALT);
  assign PC_OUT = pc;

  multicycle_seq_decode u_dec (
    .op  (op),
    .dec (dec)
  );

  // Strobes depend only on state and registers, so reset drops them at once
  always_comb begin
    mem.M_REQ    = 1'b0;
    mem.M_W      = 1'b0;
    mem.MADDR    = '0;
    mem.MDATAOUT = '0;
    R_W          = 1'b0;
    RADDR        = '0;
    RDATAOUT     = '0;
    SEL_OUT      = OP_ADD;
    DATA1_OUT    = '0;
    DATA2_OUT    = '0;
    unique case (state)
      S_FETCH: begin
        mem.M_REQ = 1'b1;
        mem.MADDR = pc_ext;
      end
      S_DECODE: RADDR = REG_A'(dec.is_alu ? r2 : r1);
      S_RDA:    RADDR = REG_A'(dec.is_branch ? r2 : r3);
      S_EXEC: begin
        SEL_OUT   = dec.is_alu ? op
                  : (dec.is_branch ? OP_SUB : OP_ADD);
        DATA1_OUT = a;
        DATA2_OUT = (dec.is_alu || dec.is_branch) ? b : imm_ext;
      end
      S_MEM: begin
        mem.M_REQ    = 1'b1;
        mem.M_W      = dec.mem_write;
        mem.MADDR    = imm_ext;
        mem.MDATAOUT = a;
      end
      S_WB: begin
        R_W      = 1'b1;
        RADDR    = REG_A'(r1);
        RDATAOUT = res;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt    = state;
    done   = 1'b0;
    pc_ld  = 1'b0;
    pc_val = pc_inc;
    unique case (state)
      S_IDLE:  if (RUN) nxt = S_FETCH;
      S_FETCH: if (mem.M_ACK) nxt = S_DECODE;
      S_DECODE: begin
        if (dec.is_halt) nxt = S_HALT;
        else if (dec.num_reads != 2'd0) nxt = S_RDA;
        else if (dec.uses_mem) nxt = S_MEM;
        else begin
          done  = 1'b1;
          pc_ld = 1'b1;
          if (dec.is_jump) pc_val = PC_W'(imm8);
        end
      end
      S_RDA: begin
        if (dec.num_reads == 2'd2) nxt = S_RDB;
        else if (dec.uses_mem) nxt = S_MEM;
        else nxt = S_EXEC;
      end
      S_RDB: nxt = S_EXEC;
      S_EXEC: begin
        if (dec.writes_reg) nxt = S_WB;
        else begin
          done  = 1'b1;
          pc_ld = 1'b1;
          if (dec.is_branch && ALU_ZERO) pc_val = pc_br;
        end
      end
      S_MEM: begin
        if (mem.M_ACK) begin
          if (dec.writes_reg) nxt = S_WB;
          else begin
            done  = 1'b1;
            pc_ld = 1'b1;
          end
        end
      end
      S_WB: begin
        done  = 1'b1;
        pc_ld = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    if (done) nxt = RUN ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge DCLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge DCLK or negedge RSTN) begin
    if (!RSTN) begin
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      res <= '0;
      pc  <= '0;
    end else begin
      if (pc_ld) pc <= pc_val;
      if (state == S_FETCH && mem.M_ACK) ir <= mem.MDATAIN;
      if (state == S_RDA) a <= RDATAIN;
      if (state == S_RDB) b <= RDATAIN;
      if (state == S_EXEC) res <= ALU_RES;
      if (state == S_MEM && mem.M_ACK) res <= mem.MDATAIN;
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench: memory, register file and ALU models around
// the sequencer, with write-back and store scoreboards.
module tb_multicycle_seq;

  logic        DCLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        RUN  = 1'b0;
  logic        BUSY, HALTED;
  logic [7:0]  PC_OUT;
  logic        R_W;
  logic [3:0]  RADDR;
  logic [15:0] RDATAOUT, RDATAIN;
  logic [3:0]  SEL_OUT;
  logic [15:0] DATA1_OUT, DATA2_OUT, ALU_RES;
  logic        ALU_ZERO;

  multicycle_seq_if #(.WORD_W(16)) mem_bus ();

  multicycle_seq dut (
    .DCLK      (DCLK),
    .RSTN      (RSTN),
    .RUN       (RUN),
    .BUSY      (BUSY),
    .HALTED    (HALTED),
    .PC_OUT    (PC_OUT),
    .mem       (mem_bus),
    .R_W       (R_W),
    .RADDR     (RADDR),
    .RDATAOUT  (RDATAOUT),
    .RDATAIN   (RDATAIN),
    .SEL_OUT   (SEL_OUT),
    .DATA1_OUT (DATA1_OUT),
    .DATA2_OUT (DATA2_OUT),
    .ALU_RES   (ALU_RES),
    .ALU_ZERO  (ALU_ZERO)
  );

  always #5 DCLK = ~DCLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;

  logic [15:0] mem_arr [256];
  logic [15:0] rf [16] = '{default: 16'h0};
  logic [15:0] rdata = 16'h0;
  logic [15:0] slow_addr = 16'hFFFF;
  int          slow_waits = 0;
  int          wcnt = 0;
  logic [19:0] rq [$];
  logic [31:0] wq [$];

  always @(posedge DCLK) cyc <= cyc + 1;

  // Memory slave: zero-wait except at slow_addr
  assign mem_bus.M_ACK = mem_bus.M_REQ &&
    ((mem_bus.MADDR != slow_addr) || (wcnt >= slow_waits));
  assign mem_bus.MDATAIN = mem_arr[mem_bus.MADDR[7:0]];

  always @(posedge DCLK) begin
    if (mem_bus.M_REQ && !mem_bus.M_ACK) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge DCLK) begin
    if (R_W) rf[RADDR] <= RDATAOUT;
    else     rdata     <= rf[RADDR];
  end
  assign RDATAIN = rdata;

  always_comb begin
    ALU_RES = 16'h0;
    case (SEL_OUT)
      4'd0: ALU_RES = DATA1_OUT + DATA2_OUT;
      4'd1: ALU_RES = DATA1_OUT - DATA2_OUT;
      4'd2: ALU_RES = DATA1_OUT & DATA2_OUT;
      4'd3: ALU_RES = DATA1_OUT | DATA2_OUT;
      4'd4: ALU_RES = {15'h0, $signed(DATA1_OUT) < $signed(DATA2_OUT)};
      default: ;
    endcase
  end
  assign ALU_ZERO = (ALU_RES == 16'h0);

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic at(input int k);
    while (cyc < base + k) @(negedge DCLK);
  endtask

  task automatic start();
    @(negedge DCLK);
    base = cyc;
    RUN  = 1'b1;
  endtask

  task automatic do_reset();
    RUN  = 1'b0;
    RSTN = 1'b0;
    repeat (2) @(negedge DCLK);
    chk("rst_pc", PC_OUT, 8'h00);
    chk("rst_flags", {BUSY, HALTED}, 2'b00);
    chk("rst_mem", {mem_bus.M_REQ, mem_bus.M_W, mem_bus.MADDR,
                    mem_bus.MDATAOUT}, 34'h0);
    chk("rst_reg", {R_W, RADDR, RDATAOUT}, 21'h0);
    chk("rst_alu", {SEL_OUT, DATA1_OUT, DATA2_OUT}, 36'h0);
    RSTN = 1'b1;
    @(negedge DCLK);
  endtask

  // Scoreboard monitor
  always @(negedge DCLK) begin
    if (R_W) begin
      if (rq.size() == 0) chk("unexp_regwr", {RADDR, RDATAOUT}, 20'h0);
      else chk("regwr", {RADDR, RDATAOUT}, rq.pop_front());
    end
    if (mem_bus.M_REQ && mem_bus.M_ACK && mem_bus.M_W) begin
      if (wq.size() == 0)
        chk("unexp_memwr", {mem_bus.MADDR, mem_bus.MDATAOUT}, 32'h0);
      else chk("memwr", {mem_bus.MADDR, mem_bus.MDATAOUT}, wq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mem_arr[8'h00] = 16'h5107;
    mem_arr[8'h01] = 16'h5209;
    mem_arr[8'h02] = 16'h5502;
    mem_arr[8'h03] = 16'h1115;
    mem_arr[8'h04] = 16'h0312;
    mem_arr[8'h05] = 16'h6420;
    mem_arr[8'h06] = 16'h7430;
    mem_arr[8'h07] = 16'h9010;
    mem_arr[8'h0F] = 16'h90FF;
    mem_arr[8'h10] = 16'h812E;
    mem_arr[8'h11] = 16'h5104;
    mem_arr[8'h12] = 16'h9010;
    mem_arr[8'h20] = 16'hBEEF;
    mem_arr[8'hFF] = 16'hA000;

    do_reset();

    rq.push_back({4'd1, 16'h0007});
    rq.push_back({4'd2, 16'h0009});
    rq.push_back({4'd5, 16'h0002});
    rq.push_back({4'd1, 16'h0005});
    rq.push_back({4'd3, 16'h000E});
    rq.push_back({4'd4, 16'hBEEF});
    rq.push_back({4'd1, 16'h0009});
    wq.push_back({16'h0030, 16'hBEEF});
    slow_addr  = 16'h0020;
    slow_waits = 3;

    start();
    at(5);  chk("addi_wb", {R_W, RADDR, RDATAOUT}, {1'b1, 4'd1, 16'h0007});
    at(6);  chk("addi_pc", PC_OUT, 8'h01);
    at(26); chk("add_exec", {SEL_OUT, DATA1_OUT, DATA2_OUT},
                {4'd0, 16'd5, 16'd9});
    at(27); chk("add_wb", {R_W, RADDR, RDATAOUT}, {1'b1, 4'd3, 16'd14});
    for (int k = 30; k <= 32; k++) begin
      at(k);
      chk("lw_wait", {mem_bus.M_REQ, mem_bus.M_ACK, mem_bus.M_W,
                      mem_bus.MADDR}, {3'b100, 16'h0020});
    end
    at(33); chk("lw_ack", {mem_bus.M_REQ, mem_bus.M_ACK}, 2'b11);
    at(34); chk("lw_wb", {R_W, RADDR, RDATAOUT}, {1'b1, 4'd4, 16'hBEEF});
    at(35); chk("lw_pc", PC_OUT, 8'h06);
    at(38); chk("sw_mem", {mem_bus.M_REQ, mem_bus.M_W, mem_bus.MADDR,
                           mem_bus.MDATAOUT}, {2'b11, 16'h0030, 16'hBEEF});
    at(41); chk("jump_pc", PC_OUT, 8'h10);
    at(46); chk("beq_ne_pc", PC_OUT, 8'h11);
    at(58); chk("beq_eq_pc", PC_OUT, 8'h0F);
    at(60); chk("jump_ff_pc", PC_OUT, 8'hFF);
    at(61); RUN = 1'b0;
    at(62); chk("wrap_idle", {BUSY, PC_OUT}, {1'b0, 8'h00});

    do_reset();
    mem_arr[8'h00] = 16'h0312;
    mem_arr[8'h01] = 16'h6620;
    rq.push_back({4'd3, 16'h0012});
    start();
    at(4); RUN = 1'b0;
    at(6); chk("run_drop_wb", {R_W, RADDR, RDATAOUT}, {1'b1, 4'd3, 16'h0012});
    at(7); chk("run_drop_idle", {BUSY, PC_OUT}, {1'b0, 8'h01});
    at(9); chk("idle_hold", {BUSY, mem_bus.M_REQ, PC_OUT}, {2'b00, 8'h01});

    start();
    at(4); chk("mem_wait_pre", {mem_bus.M_REQ, mem_bus.M_ACK, mem_bus.MADDR},
               {2'b10, 16'h0020});
    #2;
    RSTN = 1'b0;
    RUN  = 1'b0;
    #1;
    chk("rst_async", {mem_bus.M_REQ, mem_bus.M_W, R_W, BUSY, PC_OUT}, 12'h0);
    @(negedge DCLK);
    RSTN = 1'b1;

    mem_arr[8'h00] = 16'hF000;
    start();
    at(3); chk("halt", {HALTED, BUSY}, 2'b10);
    at(6); chk("halt_sticky", {HALTED, BUSY, mem_bus.M_REQ, PC_OUT},
               {3'b100, 8'h00});
    do_reset();

    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
